// File: rtl/cve2_fetch_queue.sv
// Instruction prefetch queue: issues word-aligned OBI fetches, buffers returned words,
// and realigns 16/32-bit instructions for the IF stage. A branch flushes everything.
module cve2_fetch_queue #(
  parameter int unsigned NumOutstanding = 2,
  parameter int unsigned FifoDepth      = 3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        branch_i,
  input  logic [31:0] addr_i,
  input  logic        ready_i,
  output logic        valid_o,
  output logic [31:0] rdata_o,
  output logic [31:0] addr_o,
  output logic        err_o,
  output logic        err_plus2_o,
  output logic        instr_req_o,
  output logic [31:0] instr_addr_o,
  input  logic        instr_gnt_i,
  input  logic        instr_rvalid_i,
  input  logic [31:0] instr_rdata_i,
  input  logic        instr_err_i,
  output logic        busy_o
);

  localparam int unsigned CW = $clog2(NumOutstanding + 1);
  localparam int unsigned OW = $clog2(FifoDepth + 1);

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } entry_t;

  logic [CW-1:0]             cnt_q, cnt_d;
  logic [NumOutstanding-1:0] disc_q, disc_d;
  entry_t [FifoDepth-1:0]    fifo_q, fifo_d;
  logic [OW-1:0]             occ_q, occ_d;
  logic [31:0]               req_addr_q, hold_addr_q, pc_q, pc_d;
  logic                      held_q, stale_q;

  logic [31:0] br_addr;
  logic        room, issue_gnt, push_disc, rsp_wr;
  logic        head_vld, next_vld, unal, comp, avail, fire, pop, nxt_err;
  logic [15:0] hi, nxt_lo;

  // ---------------- request side ----------------
  assign br_addr      = {addr_i[31:2], 2'b00};
  assign room         = (32'(cnt_q) < NumOutstanding) &&
                        (32'(occ_q) + 32'(cnt_q) < FifoDepth);
  assign instr_req_o  = held_q | (req_i & room);
  assign instr_addr_o = held_q ? hold_addr_q : (branch_i ? br_addr : req_addr_q);
  assign issue_gnt    = instr_req_o & instr_gnt_i;
  // A held request is stale if a branch arrived while it waited for its grant
  assign push_disc    = held_q & (stale_q | branch_i);
  assign busy_o       = instr_req_o | (cnt_q != '0);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      req_addr_q  <= '0;
      hold_addr_q <= '0;
      held_q      <= 1'b0;
      stale_q     <= 1'b0;
    end else begin
      if (branch_i)
        req_addr_q <= (issue_gnt && !held_q) ? br_addr + 32'd4 : br_addr;
      else if (issue_gnt && !(held_q && stale_q))
        req_addr_q <= req_addr_q + 32'd4;
      if (!held_q) hold_addr_q <= instr_addr_o;
      held_q <= instr_req_o & ~instr_gnt_i;
      if (instr_req_o && !instr_gnt_i) stale_q <= held_q && (stale_q || branch_i);
      else                             stale_q <= 1'b0;
    end
  end

  // In-order outstanding slots, index 0 is the oldest
  always_comb begin
    disc_d = branch_i ? '1 : disc_q;
    cnt_d  = cnt_q;
    if (instr_rvalid_i) begin
      disc_d = disc_d >> 1;
      cnt_d  = cnt_q - CW'(1);
    end
    if (issue_gnt) begin
      for (int i = 0; i < int'(NumOutstanding); i++)
        if (i == int'(cnt_d)) disc_d[i] = push_disc;
      cnt_d = cnt_d + CW'(1);
    end
  end

  assign rsp_wr = instr_rvalid_i & ~disc_q[0] & ~branch_i;

  // ---------------- realignment ----------------
  assign head_vld = (occ_q != '0);
  assign next_vld = (32'(occ_q) > 32'd1);
  assign unal     = pc_q[1];
  assign hi       = fifo_q[0].data[31:16];
  assign comp     = unal ? (hi[1:0] != 2'b11) : (fifo_q[0].data[1:0] != 2'b11);
  assign nxt_lo   = next_vld ? fifo_q[1].data[15:0] : 16'h0;
  assign nxt_err  = next_vld & fifo_q[1].err;
  assign avail    = (!unal || comp) ? head_vld
                                    : head_vld & (next_vld | fifo_q[0].err);

  assign valid_o     = avail & ~branch_i;
  assign rdata_o     = unal ? {nxt_lo, hi} : fifo_q[0].data;
  assign addr_o      = pc_q;
  assign err_o       = head_vld & (fifo_q[0].err | (unal & ~comp & nxt_err));
  assign err_plus2_o = head_vld & unal & ~comp & ~fifo_q[0].err & nxt_err;

  assign fire = valid_o & ready_i;
  // Only an aligned compressed instruction leaves part of the head word unconsumed
  assign pop  = fire & (unal | ~comp);
  assign pc_d = branch_i ? addr_i : (fire ? pc_q + (comp ? 32'd2 : 32'd4) : pc_q);

  always_comb begin
    fifo_d = fifo_q;
    occ_d  = occ_q;
    if (pop) begin
      for (int i = 0; i < int'(FifoDepth) - 1; i++) fifo_d[i] = fifo_q[i+1];
      fifo_d[FifoDepth-1] = '0;
      occ_d = occ_q - OW'(1);
    end
    if (rsp_wr) begin
      for (int i = 0; i < int'(FifoDepth); i++)
        if (i == int'(occ_d)) fifo_d[i] = {instr_rdata_i, instr_err_i};
      occ_d = occ_d + OW'(1);
    end
    if (branch_i) begin
      fifo_d = '0;
      occ_d  = '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      disc_q <= '0;
      fifo_q <= '0;
      occ_q  <= '0;
      pc_q   <= '0;
    end else begin
      cnt_q  <= cnt_d;
      disc_q <= disc_d;
      fifo_q <= fifo_d;
      occ_q  <= occ_d;
      pc_q   <= pc_d;
    end
  end

endmodule

// File: tb/tb_cve2_fetch_queue.sv
// Scoreboard bench for cve2_fetch_queue: OBI memory model plus a monitor that
// compares each consumed instruction against hand-computed expectations.
module tb_cve2_fetch_queue;
  localparam int NO = 3;
  localparam int FD = 4;

  logic clk = 0, rst = 1;
  logic req_i = 0, branch_i = 0, ready_i = 0;
  logic [31:0] addr_i = '0;
  logic valid_o, err_o, err_plus2_o, instr_req_o, busy_o;
  logic [31:0] rdata_o, addr_o, instr_addr_o;
  logic instr_gnt_i = 0, instr_rvalid_i = 0, instr_err_i = 0;
  logic [31:0] instr_rdata_i = '0;

  cve2_fetch_queue #(.NumOutstanding(NO), .FifoDepth(FD)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req_i), .branch_i(branch_i), .addr_i(addr_i),
    .ready_i(ready_i), .valid_o(valid_o), .rdata_o(rdata_o), .addr_o(addr_o),
    .err_o(err_o), .err_plus2_o(err_plus2_o), .instr_req_o(instr_req_o),
    .instr_addr_o(instr_addr_o), .instr_gnt_i(instr_gnt_i),
    .instr_rvalid_i(instr_rvalid_i), .instr_rdata_i(instr_rdata_i),
    .instr_err_i(instr_err_i), .busy_o(busy_o));

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr, data, mask;
    logic        err, err2;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int checks = 0, errors = 0, cyc = 0;
  int gcnt = 0, rsp_cnt = 0;
  bit gnt_en = 1, rsp_en = 1;
  logic [31:0] memw [logic [31:0]];
  bit          errw [logic [31:0]];
  logic [31:0] rq[$];

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (memw.exists(a)) return memw[a];
    return (a << 4) | 32'h3;
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] a, input logic [31:0] d, input logic [31:0] m,
                          input logic e, input logic e2, input int c);
    exp_t x;
    x.addr = a; x.data = d; x.mask = m; x.err = e; x.err2 = e2; x.cyc = c;
    sb.push_back(x);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 200) begin step(); n++; end
    if (sb.size() != 0) begin
      checks++; errors++;
      $display("FAIL %s timeout, %0d instructions never seen", name, sb.size());
      sb.delete();
    end
    ready_i = 0;
  endtask

  task automatic branch_to(input logic [31:0] a, input logic rq_en);
    branch_i = 1; addr_i = a; req_i = rq_en;
    step();
    branch_i = 0;
  endtask

  task automatic idle();
    req_i = 0; ready_i = 0; gnt_en = 1; rsp_en = 1;
    step();
    branch_to(32'h0, 1'b0);
    repeat (6) step();
  endtask

  initial forever begin
    @(posedge clk); cyc++;
  end

  // OBI memory: zero-wait grant when enabled, in-order response one cycle later
  initial begin
    bit          pend = 0;
    logic [31:0] pend_addr = '0;
    logic [31:0] a;
    forever begin
      @(negedge clk);
      if (rst) begin
        instr_gnt_i = 0; instr_rvalid_i = 0; pend = 0;
      end else begin
        if (pend) begin
          checks++;
          if (!(instr_req_o && instr_addr_o == pend_addr)) begin
            errors++;
            $display("FAIL obi_hold req=%b addr=%h expected req=1 addr=%h",
                     instr_req_o, instr_addr_o, pend_addr);
          end
        end
        if (rsp_en && rq.size() > 0) begin
          a = rq.pop_front();
          instr_rvalid_i = 1; instr_rdata_i = mem_rd(a); instr_err_i = errw.exists(a);
          rsp_cnt++;
        end else begin
          instr_rvalid_i = 0; instr_err_i = 0;
        end
        instr_gnt_i = instr_req_o & gnt_en;
        if (instr_gnt_i) begin rq.push_back(instr_addr_o); gcnt++; end
        pend = instr_req_o & ~instr_gnt_i;
        pend_addr = instr_addr_o;
      end
    end
  end

  // Monitor: every consumed instruction must match the head of the scoreboard
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (!rst && valid_o && ready_i) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected instr addr=%h data=%h, expected none", addr_o, rdata_o);
      end else begin
        e = sb.pop_front();
        if (((rdata_o ^ e.data) & e.mask) != 0 || addr_o !== e.addr || err_o !== e.err ||
            err_plus2_o !== e.err2 || (e.cyc >= 0 && cyc != e.cyc)) begin
          errors++;
          $display("FAIL instr got addr=%h data=%h err=%b err2=%b cyc=%0d expected addr=%h data=%h mask=%h err=%b err2=%b cyc=%0d",
                   addr_o, rdata_o, err_o, err_plus2_o, cyc, e.addr, e.data, e.mask, e.err, e.err2, e.cyc);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int c, base, n;
    repeat (3) step();
    rst = 0;
    @(negedge clk);
    chk("rst_valid", {31'b0, valid_o}, 32'd0);
    chk("rst_req",   {31'b0, instr_req_o}, 32'd0);
    chk("rst_busy",  {31'b0, busy_o}, 32'd0);
    chk("rst_addr",  addr_o, 32'd0);
    chk("rst_rdata", rdata_o, 32'd0);
    chk("rst_err",   {30'b0, err_o, err_plus2_o}, 32'd0);

    // straight-line, first valid two cycles after the branch, then one per cycle
    step();
    c = cyc;
    for (int i = 0; i < 4; i++)
      push_exp(32'h100 + 4*i, mem_rd(32'h100 + 4*i), '1, 0, 0, c + 2 + i);
    ready_i = 1;
    branch_to(32'h100, 1'b1);
    wait_drain("straight");

    // unaligned 32-bit spanning two words, then a compressed half at 0x106
    memw[32'h100] = 32'h0013_ABCD;
    memw[32'h104] = 32'hEEEE_0093;
    push_exp(32'h102, 32'h0093_0013, '1, 0, 0, -1);
    push_exp(32'h106, 32'h0000_EEEE, 32'h0000_FFFF, 0, 0, -1);
    ready_i = 1;
    branch_to(32'h102, 1'b1);
    wait_drain("unaligned");

    // mixed compressed stream
    memw[32'h100] = 32'h4501_4505;
    memw[32'h104] = 32'h0000_0513;
    push_exp(32'h100, 32'h0000_4505, 32'h0000_FFFF, 0, 0, -1);
    push_exp(32'h102, 32'h0000_4501, 32'h0000_FFFF, 0, 0, -1);
    push_exp(32'h104, 32'h0000_0513, '1, 0, 0, -1);
    ready_i = 1;
    branch_to(32'h100, 1'b1);
    wait_drain("mixed");

    // error only on the upper half
    memw[32'h200] = 32'h0013_4505;
    memw[32'h204] = 32'h0000_0093;
    errw[32'h204] = 1;
    push_exp(32'h202, 32'h0093_0013, '1, 1, 1, -1);
    ready_i = 1;
    branch_to(32'h202, 1'b1);
    wait_drain("split_err_hi");

    // error on the first word: valid without the second word
    memw[32'h300] = 32'h0013_0000;
    memw[32'h304] = 32'h0000_0093;
    errw[32'h300] = 1;
    push_exp(32'h302, 32'h0000_0013, 32'h0000_FFFF, 1, 0, -1);
    ready_i = 1;
    branch_to(32'h302, 1'b1);
    wait_drain("split_err_lo");

    // branch with two in flight and one ungranted request
    idle();
    rsp_en = 0;
    branch_to(32'h400, 1'b1);
    step();
    gnt_en = 0;
    step();
    branch_i = 1; addr_i = 32'h500; req_i = 0;
    @(negedge clk);
    chk("held_addr", {instr_req_o, instr_addr_o[30:0]}, {1'b1, 31'h408});
    step();
    branch_i = 0;
    step();
    gnt_en = 1;
    repeat (4) step();
    @(negedge clk);
    chk("busy_inflight", {31'b0, busy_o}, 32'd1);
    push_exp(32'h500, mem_rd(32'h500), '1, 0, 0, -1);
    ready_i = 1;
    base = rsp_cnt;
    rsp_en = 1;
    n = 0;
    while (rsp_cnt != base + 3 && n < 30) begin
      step(); n++;
      if (rsp_cnt == base + 2) chk("busy_last_rsp", {31'b0, busy_o}, 32'd1);
    end
    if (rsp_cnt != base + 3) begin
      checks++; errors++;
      $display("FAIL discard_rsp timeout got=%0d responses expected=3", rsp_cnt - base);
    end
    @(negedge clk);
    chk("busy_fall", {31'b0, busy_o}, 32'd0);
    chk("discard_empty", {31'b0, valid_o}, 32'd0);
    step();
    req_i = 1;
    wait_drain("branch_target");

    // back-pressure: only FifoDepth words requested, nothing lost afterwards
    idle();
    base = gcnt;
    branch_to(32'h600, 1'b1);
    repeat (10) step();
    @(negedge clk);
    chk("bp_grants", gcnt - base, FD);
    chk("bp_req_low", {31'b0, instr_req_o}, 32'd0);
    for (int i = 0; i < 6; i++)
      push_exp(32'h600 + 4*i, mem_rd(32'h600 + 4*i), '1, 0, 0, -1);
    step();
    ready_i = 1;
    wait_drain("backpressure");

    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
